// File: rtl/dffram_seq_pkg.sv
// Shared types and constants for the DFF RAM byte sequencer.
// Holds the sequencer state encoding, word geometry and the macro idle pair.
// No logic; imported by the sequencer top and its lane-pick helper.
package dffram_seq_pkg;

    // Sequencer phases: wait for a request, walk the byte lanes, collect the
    // last read byte, then pulse the response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // Highest byte lane index within a word.
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // {cen, gwen} pair that leaves the macro untouched.
    localparam logic [1:0] RAM_INACTIVE = 2'b11;

endpackage

// File: rtl/dffram_seq_lane_pick.sv
// Finds the lowest set strobe lane at or above a starting lane index.
// Purely combinational, zero latency.
// No handshake; caller decides when the result is consumed.
module dffram_seq_lane_pick
    import dffram_seq_pkg::*;
(
    input  logic [3:0] mask_i,
    input  logic [2:0] from_i,
    output logic       found_o,
    output logic [1:0] lane_o
);

    // Scan high to low so the lowest qualifying lane is the one that sticks.
    always_comb begin
        found_o = 1'b0;
        lane_o  = 2'd0;
        for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
            if (mask_i[i] && (3'(i) >= from_i)) begin
                found_o = 1'b1;
                lane_o  = 2'(i);
            end
        end
    end

endmodule

// File: rtl/dffram_byte_sequencer.sv
// Serialises 32-bit word requests into four byte accesses on a 512x8 DFF RAM macro.
// Latency: read response 6 cycles after handshake, write 5 (DFFRAM_SEQ_SKIP_EN: 1+popcount(wstrb)).
// Backpressure: req_ready low while a word is in flight; rsp_valid is a one-cycle pulse, no backpressure.
module dffram_byte_sequencer
    import dffram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-3:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  ram_cen,
    output logic                  ram_gwen,
    output logic [3:0]            ram_wmask,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_d,
    input  logic [7:0]            ram_q
);

    localparam int WA = ADDR_WIDTH - 2;

    state_e          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic            we_q;
    logic [WA-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [23:0]     rbuf_q;
    logic [31:0]     rdata_q;
    logic            hs;

    assign hs = req_valid && (state_q == IDLE);

`ifdef DFFRAM_SEQ_SKIP_EN
    logic       idle_found, acc_found;
    logic [1:0] idle_lane,  acc_lane;

    // First enabled lane of an incoming write.
    dffram_seq_lane_pick u_pick_idle (
        .mask_i  (req_wstrb),
        .from_i  (3'd0),
        .found_o (idle_found),
        .lane_o  (idle_lane)
    );

    // Next enabled lane after the one being accessed now.
    dffram_seq_lane_pick u_pick_acc (
        .mask_i  (wstrb_q),
        .from_i  ({1'b0, k_q} + 3'd1),
        .found_o (acc_found),
        .lane_o  (acc_lane)
    );
`endif

    // State and lane counter registers; reset aborts any word in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic: walk lanes, add a drain cycle for reads, then respond.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
`ifdef DFFRAM_SEQ_SKIP_EN
                    if (req_we) begin
                        if (idle_found) begin
                            state_d = ACCESS;
                            k_d     = idle_lane;
                        end else begin
                            state_d = RESP;
                            k_d     = 2'd0;
                        end
                    end else begin
                        state_d = ACCESS;
                        k_d     = 2'd0;
                    end
`else
                    state_d = ACCESS;
                    k_d     = 2'd0;
`endif
                end
            end
            ACCESS: begin
`ifdef DFFRAM_SEQ_SKIP_EN
                if (we_q) begin
                    if (acc_found) begin
                        k_d = acc_lane;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                    if (k_q == LAST_LANE) begin
                        state_d = DRAIN;
                    end
                end
`else
                k_d = k_q + 2'd1;
                if (k_q == LAST_LANE) begin
                    state_d = we_q ? RESP : DRAIN;
                end
`endif
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
            default: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
        endcase
    end

    // Request capture on handshake; held stable for the whole word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (hs) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // Read data collection: macro Q lags the address by one cycle, so lane k-1
    // arrives while lane k is addressed and lane 3 arrives in DRAIN. The
    // visible response word only updates once all four bytes are in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rbuf_q  <= 24'd0;
            rdata_q <= 32'd0;
        end else if (state_q == ACCESS && !we_q) begin
            case (k_q)
                2'd1:    rbuf_q[7:0]   <= ram_q;
                2'd2:    rbuf_q[15:8]  <= ram_q;
                2'd3:    rbuf_q[23:16] <= ram_q;
                default: rbuf_q        <= rbuf_q;
            endcase
        end else if (state_q == DRAIN) begin
            rdata_q <= {ram_q, rbuf_q};
        end
    end

    // Bus and macro outputs, decoded from registered state only.
    always_comb begin
        req_ready           = (state_q == IDLE);
        rsp_valid           = (state_q == RESP);
        rsp_rdata           = rdata_q;
        ram_wmask           = 4'hF;
        {ram_cen, ram_gwen} = RAM_INACTIVE;
        ram_a               = '0;
        ram_d               = 8'd0;
        if (state_q == ACCESS) begin
            ram_a = {addr_q, k_q};
            ram_d = 8'(wdata_q >> {k_q, 3'b000});
            if (we_q) begin
                // Disabled lanes keep the macro idle but still use their slot.
                ram_cen  = ~wstrb_q[k_q];
                ram_gwen = ~wstrb_q[k_q];
            end else begin
                ram_cen  = 1'b0;
                ram_gwen = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dffram_byte_sequencer.sv
// Randomised scoreboard bench for dffram_byte_sequencer with a behavioural macro.
// Reference model works on whole words with byte strobes.
// Checks handshake timing, response latency/data, macro traffic and final memory contents.
module tb_dffram_byte_sequencer;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        ram_cen;
    logic        ram_gwen;
    logic [3:0]  ram_wmask;
    logic [8:0]  ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;

    dffram_byte_sequencer #(.ADDR_WIDTH(9)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cen   (ram_cen),
        .ram_gwen  (ram_gwen),
        .ram_wmask (ram_wmask),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    typedef struct {
        bit          we;
        int unsigned addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          rsp_cyc;
        int          cen_cnt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          busy_lo = 0;
    int          busy_hi = 0;
    int          cen_seen = 0;
    int          last_T = 0;
    logic [7:0]  init_bytes [512];
    logic [7:0]  mac [512];
    bit          mac_init = 1'b0;
    logic [31:0] model [128];
    logic [31:0] last_rd = 32'd0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural macro: active-low enables, registered read data.
    always @(posedge CLK) begin
        if (!mac_init) begin
            for (int i = 0; i < 512; i++) mac[i] <= init_bytes[i];
            mac_init <= 1'b1;
        end else if (!ram_cen) begin
            if (!ram_gwen) mac[ram_a] <= ram_d;
            else           ram_q <= mac[ram_a];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int popc(input logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) if (s[i]) n++;
        return n;
    endfunction

    function automatic int wr_lat(input logic [3:0] s);
`ifdef DFFRAM_SEQ_SKIP_EN
        return 1 + popc(s);
`else
        return 5 + 0 * popc(s);
`endif
    endfunction

    // Monitor: handshake windows, macro traffic and responses.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("req_ready", {31'd0, req_ready},
                (cyc > busy_lo && cyc <= busy_hi) ? 32'd0 : 32'd1);
            if (!ram_cen) begin
                cen_seen++;
                if (sbq.size() == 0) begin
                    chk("cen_outstanding", sbq.size(), 1);
                end else begin
                    chk("ram_a_word", {23'd0, ram_a[8:2]}, sbq[0].addr);
                    chk("ram_gwen", {31'd0, ram_gwen}, {31'd0, !sbq[0].we});
                    if (!ram_gwen) begin
                        chk("lane_strobe", {31'd0, sbq[0].wstrb[ram_a[1:0]]}, 32'd1);
                        chk("ram_d", {24'd0, ram_d},
                            (sbq[0].wdata >> (8 * int'(ram_a[1:0]))) & 32'hFF);
                    end
                end
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("rsp_outstanding", sbq.size(), 1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rsp_cycle", cyc, mon_e.rsp_cyc);
                    chk("rsp_rdata", rsp_rdata, mon_e.exp_rdata);
                    chk("cen_cycles", cen_seen, mon_e.cen_cnt);
                    cen_seen = 0;
                end
            end
        end
    end

    task automatic issue(input bit we, input int unsigned addr, input logic [31:0] wd,
                         input logic [3:0] ws);
        exp_t e;
        int   waited = 0;
        bit   ok = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr[6:0];
        req_wdata = wd;
        req_wstrb = ws;
        while (!ok && waited < 50) begin
            @(negedge CLK);
            if (req_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            chk("handshake_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.we    = we;
        e.addr  = addr;
        e.wdata = wd;
        e.wstrb = ws;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (ws[i]) model[addr][8*i +: 8] = wd[8*i +: 8];
            e.exp_rdata = last_rd;
            e.rsp_cyc   = cyc + wr_lat(ws);
            e.cen_cnt   = popc(ws);
        end else begin
            e.exp_rdata = model[addr];
            last_rd     = model[addr];
            e.rsp_cyc   = cyc + 6;
            e.cen_cnt   = 4;
        end
        sbq.push_back(e);
        last_T  = cyc;
        busy_lo = cyc;
        busy_hi = e.rsp_cyc;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_ram_cen"},   {31'd0, ram_cen}, 32'd1);
        chk({tag, "_ram_gwen"},  {31'd0, ram_gwen}, 32'd1);
        chk({tag, "_ram_a"},     {23'd0, ram_a}, 32'd0);
        chk({tag, "_ram_d"},     {24'd0, ram_d}, 32'd0);
        chk({tag, "_ram_wmask"}, {28'd0, ram_wmask}, 32'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_w, new_w;
        int          guard;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 7'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
        for (int i = 0; i < 512; i++) init_bytes[i] = 8'($urandom);
        for (int w = 0; w < 128; w++)
            model[w] = {init_bytes[4*w+3], init_bytes[4*w+2], init_bytes[4*w+1], init_bytes[4*w]};

        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Full-word write then read back of word 5.
        issue(1'b1, 5, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 5, 32'd0, 4'h0);
        wait_idle();
        chk("word5_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("mac20", {24'd0, mac[20]}, 32'hEF);
        chk("mac21", {24'd0, mac[21]}, 32'hBE);
        chk("mac22", {24'd0, mac[22]}, 32'hAD);
        chk("mac23", {24'd0, mac[23]}, 32'hDE);

        // Partial-strobe merge on word 3.
        issue(1'b1, 3, 32'h11223344, 4'hF);
        issue(1'b1, 3, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 3, 32'd0, 4'h0);
        wait_idle();
        chk("word3_rdata", rsp_rdata, 32'h11BB33DD);

        // Back-to-back reads with valid held.
        issue(1'b0, 5, 32'd0, 4'h0);
        issue(1'b0, 3, 32'd0, 4'h0);
        wait_idle();

        // Reset while lane 2 of a write is on the macro.
        old_w = model[9];
        issue(1'b1, 9, $urandom, 4'hF);
        new_w = model[9];
        guard = 0;
        while (cyc != last_T + 3 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        RST = 1'b1;
        #1;
        chk_reset_outputs("midop");
        sbq.delete();
        cen_seen = 0;
        busy_lo  = 0;
        busy_hi  = 0;
        last_rd  = 32'd0;
        model[9] = {old_w[31:16], new_w[15:0]};
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        issue(1'b0, 9, 32'd0, 4'h0);
        wait_idle();

        // Empty-strobe write leaves word 127 intact.
        issue(1'b1, 127, 32'hCAFEF00D, 4'h0);
        issue(1'b0, 127, 32'd0, 4'h0);
        wait_idle();

        // Single top lane write.
        issue(1'b1, 40, 32'h5A000000, 4'b1000);
        issue(1'b0, 40, 32'd0, 4'h0);
        wait_idle();

        // Random traffic with occasional idle gaps.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom,
                  4'($urandom_range(0, 15)));
        end
        wait_idle();

        for (int w = 0; w < 128; w++)
            chk("final_mem", {mac[4*w+3], mac[4*w+2], mac[4*w+1], mac[4*w]}, model[w]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
